// File: rtl/fd_sched_pkg.sv
// Shared sizing and FSM encoding for the fetch/decode issue scheduler.
package fd_sched_pkg;

    localparam int unsigned SLOTS   = 8;
    localparam int unsigned ISSUE_W = 4;
    localparam int unsigned SLOT_W  = 3;

    typedef enum logic {
        StEmpty,
        StHold
    } state_e;

endpackage

// File: rtl/fd_issue_sched_slot_picker.sv
// Lowest-set-bit slot selection: port k takes the (k+1)-th lowest pending slot.
module slot_picker import fd_sched_pkg::*; #(
    parameter int unsigned SLOTS   = fd_sched_pkg::SLOTS,
    parameter int unsigned ISSUE_W = fd_sched_pkg::ISSUE_W
) (
    input  logic [SLOTS-1:0]                  mask,
    input  logic [2:0]                        budget,
    output logic [ISSUE_W-1:0]                port_valid,
    output logic [ISSUE_W-1:0][SLOT_W-1:0]    port_slot,
    output logic [SLOTS-1:0]                  issued
);

    logic [SLOTS-1:0] rem;
    logic             found;

    always_comb begin
        rem        = mask;
        issued     = '0;
        port_valid = '0;
        port_slot  = '0;
        found      = 1'b0;
        for (int k = 0; k < int'(ISSUE_W); k++) begin
            found = 1'b0;
            if (k < int'(budget)) begin
                for (int s = 0; s < int'(SLOTS); s++) begin
                    if (!found && rem[s]) begin
                        found         = 1'b1;
                        port_valid[k] = 1'b1;
                        port_slot[k]  = SLOT_W'(s);
                        rem[s]        = 1'b0;
                        issued[s]     = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fd_issue_sched.sv
// Holds one fetch bundle as a pending-slot mask and issues it to decode ports,
// loading the next bundle back-to-back when the current one fully drains.
module fd_issue_sched import fd_sched_pkg::*; #(
    parameter int unsigned SLOTS   = fd_sched_pkg::SLOTS,
    parameter int unsigned ISSUE_W = fd_sched_pkg::ISSUE_W
) (
    input  logic                              clk,
    input  logic                              CLR,
    input  logic                              bundle_valid,
    input  logic [SLOTS-1:0]                  bundle_mask,
    input  logic [2:0]                        issue_budget,
    input  logic                              flush,
    output logic                              fd_load,
    output logic                              fd_clr,
    output logic                              fetch_stall,
    output logic [ISSUE_W-1:0]                port_valid,
    output logic [ISSUE_W-1:0][SLOT_W-1:0]    port_slot,
    output logic [15:0]                       stall_cnt
);

    state_e                           state_q, state_d;
    logic [SLOTS-1:0]                 mask_q, mask_d;
    logic [SLOTS-1:0]                 remain;
    logic [SLOTS-1:0]                 pick_issued;
    logic [ISSUE_W-1:0]               pick_valid;
    logic [ISSUE_W-1:0][SLOT_W-1:0]   pick_slot;
    logic [2:0]                       budget_c;
    logic                             issue_ok;
    logic                             want_load;
    logic [15:0]                      stall_cnt_q;

    assign budget_c  = (issue_budget > 3'(ISSUE_W)) ? 3'(ISSUE_W) : issue_budget;
    assign stall_cnt = stall_cnt_q;

    slot_picker #(
        .SLOTS   (SLOTS),
        .ISSUE_W (ISSUE_W)
    ) u_picker (
        .mask       (mask_q),
        .budget     (budget_c),
        .port_valid (pick_valid),
        .port_slot  (pick_slot),
        .issued     (pick_issued)
    );

    always_comb begin
        port_valid  = '0;
        port_slot   = '0;
        fd_load     = 1'b0;
        fetch_stall = 1'b0;
        fd_clr      = CLR | flush;
        mask_d      = mask_q;
        state_d     = state_q;
        remain      = mask_q;
        issue_ok    = !CLR && !flush && (state_q == StHold);
        want_load   = bundle_valid && (|bundle_mask) && !CLR && !flush;

        if (issue_ok) begin
            port_valid = pick_valid;
            port_slot  = pick_slot;
            remain     = mask_q & ~pick_issued;
        end

        // A bundle may load only into an empty holder or one this cycle's issue empties.
        if (want_load) begin
            if ((state_q == StEmpty) || (remain == '0)) begin
                fd_load = 1'b1;
            end else begin
                fetch_stall = 1'b1;
            end
        end

        unique case (state_q)
            StEmpty: begin
                if (fd_load) begin
                    state_d = StHold;
                    mask_d  = bundle_mask;
                end
            end
            StHold: begin
                if (fd_load) begin
                    mask_d = bundle_mask;
                end else if (remain == '0) begin
                    state_d = StEmpty;
                    mask_d  = '0;
                end else begin
                    mask_d = remain;
                end
            end
            default: begin
                state_d = StEmpty;
                mask_d  = '0;
            end
        endcase

        if (CLR || flush) begin
            state_d = StEmpty;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q     <= StEmpty;
            mask_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            if (fetch_stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fd_issue_sched.sv
// Randomised bench for fd_issue_sched against a queue-based behavioural model,
// plus directed scenarios pinned with hand-computed values.
module tb_fd_issue_sched;

    logic             clk = 1'b0;
    logic             CLR;
    logic             bundle_valid;
    logic [7:0]       bundle_mask;
    logic [2:0]       issue_budget;
    logic             flush;
    logic             fd_load;
    logic             fd_clr;
    logic             fetch_stall;
    logic [3:0]       port_valid;
    logic [3:0][2:0]  port_slot;
    logic [15:0]      stall_cnt;

    int errors = 0;
    int checks = 0;

    // Model state: pending slots and stall count.
    logic [7:0] m_mask;
    int         m_cnt;

    // DUT outputs sampled mid-cycle by the last step.
    logic        s_load, s_stall, s_clr;
    logic [3:0]  s_pv;
    logic [11:0] s_ps;

    always #5 clk = ~clk;

    fd_issue_sched dut (
        .clk          (clk),
        .CLR          (CLR),
        .bundle_valid (bundle_valid),
        .bundle_mask  (bundle_mask),
        .issue_budget (issue_budget),
        .flush        (flush),
        .fd_load      (fd_load),
        .fd_clr       (fd_clr),
        .fetch_stall  (fetch_stall),
        .port_valid   (port_valid),
        .port_slot    (port_slot),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle from the negedge, compare against the model, advance the model.
    task automatic step(input bit c, input bit bv, input logic [7:0] bm, input int bud,
                        input bit fl);
        int          q[$];
        int          clamp;
        int          n;
        logic [3:0]  e_pv;
        logic [11:0] e_ps;
        logic [7:0]  issued;
        bit          e_load;
        bit          e_stall;

        CLR          = c;
        bundle_valid = bv;
        bundle_mask  = bm;
        issue_budget = 3'(bud);
        flush        = fl;
        #1;

        clamp = (bud > 4) ? 4 : bud;
        for (int s = 0; s < 8; s++) if (m_mask[s]) q.push_back(s);
        n = (c || fl) ? 0 : ((q.size() < clamp) ? q.size() : clamp);
        e_pv   = '0;
        e_ps   = '0;
        issued = '0;
        for (int k = 0; k < n; k++) begin
            e_pv[k]         = 1'b1;
            e_ps[k*3 +: 3]  = 3'(q[k]);
            issued[q[k]]    = 1'b1;
        end
        e_load  = !c && !fl && bv && (bm != 0) && (q.size() <= clamp);
        e_stall = !c && !fl && bv && (bm != 0) && !e_load;

        s_pv    = port_valid;
        s_ps    = port_slot;
        s_load  = fd_load;
        s_stall = fetch_stall;
        s_clr   = fd_clr;

        chk("port_valid", int'(s_pv), int'(e_pv));
        chk("port_slot", int'(s_ps), int'(e_ps));
        chk("fd_load", int'(s_load), int'(e_load));
        chk("fetch_stall", int'(s_stall), int'(e_stall));
        chk("fd_clr", int'(s_clr), int'(c | fl));
        chk("stall_cnt", int'(stall_cnt), m_cnt);

        @(posedge clk);
        if (c || fl)     m_mask = '0;
        else if (e_load) m_mask = bm;
        else             m_mask = m_mask & ~issued;
        if (c)                               m_cnt = 0;
        else if (e_stall && m_cnt < 65535)   m_cnt++;
        @(negedge clk);
    endtask

    initial begin
        CLR          = 1'b1;
        bundle_valid = 1'b0;
        bundle_mask  = '0;
        issue_budget = '0;
        flush        = 1'b0;
        m_mask       = '0;
        m_cnt        = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset behaviour, including a bundle offered while in reset.
        step(1, 1, 8'hFF, 4, 0);
        chk("rst_fd_clr", int'(s_clr), 1);
        chk("rst_pv", int'(s_pv), 0);
        chk("rst_load", int'(s_load), 0);
        chk("rst_cnt", int'(stall_cnt), 0);

        // Full bundle, budget 4: two issue cycles, back-to-back reload.
        step(0, 1, 8'hFF, 4, 0);
        chk("b2b_load0", int'(s_load), 1);
        step(0, 0, 8'h00, 4, 0);
        chk("b2b_pv1", int'(s_pv), 4'hF);
        chk("b2b_ps1", int'(s_ps), 12'h688);
        step(0, 1, 8'hFF, 4, 0);
        chk("b2b_ps2", int'(s_ps), 12'hFAC);
        chk("b2b_load2", int'(s_load), 1);
        chk("b2b_stall2", int'(s_stall), 0);
        step(0, 0, 8'h00, 0, 1);

        // Sparse mask, budget 2.
        step(0, 1, 8'hA6, 2, 0);
        chk("sp_load", int'(s_load), 1);
        step(0, 1, 8'hFF, 2, 0);
        chk("sp_pv1", int'(s_pv), 4'h3);
        chk("sp_ps1", int'(s_ps), 12'h011);
        chk("sp_stall1", int'(s_stall), 1);
        step(0, 1, 8'hFF, 2, 0);
        chk("sp_ps2", int'(s_ps), 12'h03D);
        chk("sp_stall2", int'(s_stall), 0);
        step(0, 0, 8'h00, 0, 1);

        // Flush overriding a presented bundle.
        step(0, 1, 8'h0F, 4, 0);
        step(0, 1, 8'hFF, 4, 1);
        chk("fl_pv", int'(s_pv), 0);
        chk("fl_clr", int'(s_clr), 1);
        chk("fl_load", int'(s_load), 0);
        step(0, 0, 8'h00, 4, 0);
        chk("fl_after_pv", int'(s_pv), 0);

        // Budget clamp and zero budget.
        step(0, 1, 8'hFF, 7, 0);
        step(0, 0, 8'h00, 7, 0);
        chk("clamp_pv", int'(s_pv), 4'hF);
        chk("clamp_ps", int'(s_ps), 12'h688);
        step(0, 1, 8'hFF, 0, 0);
        chk("zb_pv", int'(s_pv), 0);
        chk("zb_stall", int'(s_stall), 1);
        step(0, 0, 8'h00, 4, 0);
        chk("zb_held_ps", int'(s_ps), 12'hFAC);

        // Empty bundle is consumed without effect.
        step(0, 1, 8'h00, 4, 0);
        chk("zm_load", int'(s_load), 0);
        chk("zm_stall", int'(s_stall), 0);
        step(0, 0, 8'h00, 4, 0);
        chk("zm_pv", int'(s_pv), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) == 0,
                 $urandom_range(3) != 0,
                 ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom),
                 int'($urandom_range(7)),
                 $urandom_range(19) == 0);
        end

        // Drive the stall counter into saturation, then clear it.
        step(0, 0, 8'h00, 0, 1);
        step(0, 1, 8'hFF, 0, 0);
        for (int i = 0; i < 65540; i++) step(0, 1, 8'hFF, 0, 0);
        chk("sat_cnt", int'(stall_cnt), 16'hFFFF);
        step(1, 0, 8'h00, 0, 0);
        chk("sat_clr", int'(stall_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
